if_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of next-PC selection.
- Holds the architectural PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Captures the returned instruction into IF/ID (pc4_ID, Instr_ID, valid_ID).
- Accepts redirects (branch/jump/jr target) from the ID-stage next-PC logic and honours ID stalls.

---
 rtl/if_stage.sv | 110 +++++++++++
 tb/tb_if_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// One outstanding imem request at a time; redirects flush IF/ID and kill in-flight fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_ID,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_IF,
  output logic        valid_ID,
  output logic [31:0] pc4_ID,
  output logic [31:0] Instr_ID
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StBuf, StDrop} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] fetch_addr_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_addr_q;
  logic        valid_id_q;
  logic [31:0] pc4_id_q;
  logic [31:0] instr_id_q;

  logic        can_accept;
  logic        offer_valid;
  logic [31:0] offer_instr;
  logic [31:0] offer_addr;

  // Word offered to IF/ID this cycle: fresh memory data in WAIT, or the skid entry in BUF.
  always_comb begin
    can_accept  = !valid_id_q || !stall_ID;
    offer_valid = ((state_q == StWait) && imem_rvalid) || (state_q == StBuf);
    offer_instr = (state_q == StBuf) ? skid_instr_q : imem_rdata;
    offer_addr  = (state_q == StBuf) ? skid_addr_q : fetch_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      fetch_addr_q <= '0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      valid_id_q   <= 1'b0;
      pc4_id_q     <= '0;
      instr_id_q   <= '0;
    end else if (redirect) begin
      // Redirect overrides gnt and stall; any outstanding response must be dropped.
      pc_q         <= redirect_pc & ~32'h3;
      valid_id_q   <= 1'b0;
      instr_id_q   <= '0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      case (state_q)
        StReq:   state_q <= imem_gnt ? StDrop : StReq;
        StWait:  state_q <= imem_rvalid ? StReq : StDrop;
        StBuf:   state_q <= StReq;
        StDrop:  state_q <= imem_rvalid ? StReq : StDrop;
        default: state_q <= StReq;
      endcase
    end else begin
      if (can_accept) begin
        valid_id_q <= offer_valid;
        instr_id_q <= offer_valid ? offer_instr : '0;
        if (offer_valid) pc4_id_q <= offer_addr + 32'd4;
      end
      case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (imem_gnt) begin
            pc_q         <= pc_q + 32'd4;
            fetch_addr_q <= pc_q;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (can_accept) begin
              state_q <= StReq;
            end else begin
              skid_instr_q <= imem_rdata;
              skid_addr_q  <= fetch_addr_q;
              state_q      <= StBuf;
            end
          end
        end
        StBuf:   if (can_accept) state_q <= StReq;
        StDrop:  if (imem_rvalid) state_q <= StReq;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;
  assign pc_IF     = pc_q;
  assign valid_ID  = valid_id_q;
  assign pc4_ID    = pc4_id_q;
  assign Instr_ID  = instr_id_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a simple memory responder (word = ~address).
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_ID;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_IF;
  logic        valid_ID;
  logic [31:0] pc4_ID;
  logic [31:0] Instr_ID;

  logic        gnt_en;
  logic [1:0]  lat;
  logic        pend_q  = 1'b0;
  logic [1:0]  cnt_q   = 2'd0;
  logic [31:0] raddr_q = 32'd0;

  int n_vec = 0;
  int n_err = 0;

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_ID    (stall_ID),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc_IF       (pc_IF),
    .valid_ID    (valid_ID),
    .pc4_ID      (pc4_ID),
    .Instr_ID    (Instr_ID)
  );

  always #5 clk = ~clk;

  // Memory: grants whenever enabled, answers 'lat' cycles after the earliest slot.
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = pend_q && (cnt_q == 2'd0);
  assign imem_rdata  = imem_rvalid ? ~raddr_q : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (pend_q && cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
    if (imem_rvalid) pend_q <= 1'b0;
    if (imem_gnt) begin
      pend_q  <= 1'b1;
      cnt_q   <= lat;
      raddr_q <= imem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall_ID = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt_en = 1'b1; lat = 2'd0;
    step(); step();
    chk("rst_pc", pc_IF, 32'h3000);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(valid_ID), 32'd0);
    chk("rst_pc4", pc4_ID, 32'd0);
    chk("rst_instr", Instr_ID, 32'd0);
    rst_n = 1'b1;

    // Streaming fetch, 1-cycle memory
    step(); chk("e1_req", 32'(imem_req), 32'd1); chk("e1_addr", imem_addr, 32'h3000);
    step(); chk("e2_req", 32'(imem_req), 32'd0); chk("e2_valid", 32'(valid_ID), 32'd0);
    step(); chk("e3_valid", 32'(valid_ID), 32'd1); chk("e3_instr", Instr_ID, ~32'h3000);
    chk("e3_pc4", pc4_ID, 32'h3004); chk("e3_addr", imem_addr, 32'h3004);
    step(); chk("e4_valid", 32'(valid_ID), 32'd0); chk("e4_instr", Instr_ID, 32'd0);
    step(); chk("e5_valid", 32'(valid_ID), 32'd1); chk("e5_instr", Instr_ID, ~32'h3004);
    chk("e5_pc4", pc4_ID, 32'h3008); chk("e5_addr", imem_addr, 32'h3008);

    // Stall 5 cycles while the 0x3008 response returns
    stall_ID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(valid_ID), 32'd1);
      chk("stall_instr", Instr_ID, ~32'h3004);
      chk("stall_pc4", pc4_ID, 32'h3008);
    end
    stall_ID = 1'b0;
    step(); chk("skid_valid", 32'(valid_ID), 32'd1); chk("skid_instr", Instr_ID, ~32'h3008);
    chk("skid_pc4", pc4_ID, 32'h300C); chk("skid_req", 32'(imem_req), 32'd1);
    chk("skid_addr", imem_addr, 32'h300C);

    // Redirect to 0x4001 during WAIT, response 2 cycles later
    lat = 2'd2;
    step(); chk("w_valid", 32'(valid_ID), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_4001;
    step(); redirect = 1'b0;
    chk("rw_pc", pc_IF, 32'h4000); chk("rw_req", 32'(imem_req), 32'd0);
    chk("rw_valid", 32'(valid_ID), 32'd0);
    step(); chk("rw_drop_req", 32'(imem_req), 32'd0); chk("rw_drop_valid", 32'(valid_ID), 32'd0);
    step(); chk("rw_addr", imem_addr, 32'h4000); chk("rw_req2", 32'(imem_req), 32'd1);
    chk("rw_valid2", 32'(valid_ID), 32'd0); chk("rw_instr2", Instr_ID, 32'd0);
    lat = 2'd0;
    step();
    step(); chk("rw_fvalid", 32'(valid_ID), 32'd1); chk("rw_finstr", Instr_ID, ~32'h4000);
    chk("rw_fpc4", pc4_ID, 32'h4004);

    // Redirect under stall flushes IF/ID; lands pc on 0x3010
    stall_ID = 1'b1; redirect = 1'b1; redirect_pc = 32'h3010; gnt_en = 1'b0;
    step(); chk("rs_valid", 32'(valid_ID), 32'd0); chk("rs_instr", Instr_ID, 32'd0);
    chk("rs_pc", pc_IF, 32'h3010); chk("rs_req", 32'(imem_req), 32'd1);

    // Redirect in the same cycle as gnt at 0x3010
    gnt_en = 1'b1; redirect_pc = 32'h5000; stall_ID = 1'b0;
    step(); redirect = 1'b0;
    chk("rg_pc", pc_IF, 32'h5000); chk("rg_req", 32'(imem_req), 32'd0);
    step(); chk("rg_addr", imem_addr, 32'h5000); chk("rg_valid", 32'(valid_ID), 32'd0);
    step();
    step(); chk("rg_fvalid", 32'(valid_ID), 32'd1); chk("rg_finstr", Instr_ID, ~32'h5000);
    chk("rg_fpc4", pc4_ID, 32'h5004);

    // Wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; gnt_en = 1'b0;
    step(); redirect = 1'b0; gnt_en = 1'b1;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC); chk("wr_valid", 32'(valid_ID), 32'd0);
    step(); chk("wr_pc", pc_IF, 32'h0);
    step(); chk("wr_instr", Instr_ID, 32'h3); chk("wr_pc4", pc4_ID, 32'h0);
    chk("wr_addr2", imem_addr, 32'h0); chk("wr_req2", 32'(imem_req), 32'd1);

    // Reset during WAIT, stale rvalid afterwards
    lat = 2'd2;
    step();
    rst_n = 1'b0;
    #1;
    chk("mr_pc", pc_IF, 32'h3000); chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_valid", 32'(valid_ID), 32'd0); chk("mr_instr", Instr_ID, 32'd0);
    chk("mr_pc4", pc4_ID, 32'd0);
    step(); rst_n = 1'b1;
    step(); gnt_en = 1'b0; lat = 2'd0;
    chk("mr_req2", 32'(imem_req), 32'd1); chk("mr_addr2", imem_addr, 32'h3000);
    step(); chk("mr_stale_valid", 32'(valid_ID), 32'd0); chk("mr_stale_instr", Instr_ID, 32'd0);
    chk("mr_stale_addr", imem_addr, 32'h3000); chk("mr_stale_req", 32'(imem_req), 32'd1);
    gnt_en = 1'b1;
    step();
    step(); chk("mr_fvalid", 32'(valid_ID), 32'd1); chk("mr_finstr", Instr_ID, ~32'h3000);
    chk("mr_fpc4", pc4_ID, 32'h3004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
